partition_sweep_checker: RTL
============================

// Module: partition_sweep_checker
// PURPOSE
//  Hardware exhaustive-sweep checker for one approximated partition. Drives every input pattern
//  0..2^N_IN-1 onto the exact and approximate partition copies, one per cycle. Compares their
//  outputs and accumulates error metrics: mismatch count, Hamming sum, absolute-error sum, max error.
//  Sits beside the partition under test and replaces the per-pattern $display sweep for large N_IN.
// PARAMETERS
//  N_IN     7   partition input width; sweep length = 2^N_IN patterns (1..20)
//  N_OUT    4   partition output width; outputs read as unsigned integers (1..32)
//  DUT_LAT  0   pipeline depth of both partition copies in cycles (0 = combinational, 0..8)
// PORTS
//  clk        in   1                   rising-edge clock
//  rst_n      in   1                   asynchronous active-low reset
//  start      in   1                   1-cycle request; honoured only in IDLE
//  abort      in   1                   cancels a running sweep
//  pi         out  N_IN                pattern driven to both partition copies
//  po_exact   in   N_OUT               exact partition output
//  po_apx     in   N_OUT               approximate partition output
//  busy       out  1                   high in SWEEP and DRAIN
//  done       out  1                   level; high from sweep completion until next accepted start
//  mism_cnt   out  N_IN+1              patterns with po_apx != po_exact
//  ham_sum    out  N_IN+$clog2(N_OUT+1) total differing output bits
//  abs_sum    out  N_IN+N_OUT          sum of |po_apx - po_exact|
//  max_err    out  N_OUT               max |po_apx - po_exact|
//  first_fail out  N_IN                lowest failing pattern; valid when fail_vld
//  fail_vld   out  1                   at least one mismatch recorded
// BEHAVIOUR
//  - Reset (async, any state): FSM=IDLE; pi, busy, done, all metrics, first_fail, fail_vld = 0.
//  - FSM states: IDLE -> SWEEP -> DRAIN -> DONE -> IDLE.
//    IDLE: start & !abort -> clear all metrics, fail_vld, done; go to SWEEP. abort wins over start.
//    SWEEP: pi increments by 1 per cycle from 0. After pi = 2^N_IN-1 is driven, go to DRAIN.
//    DRAIN: lasts DUT_LAT cycles; 0 cycles when DUT_LAT = 0.
//    DONE: held for 1 cycle with done set, then back to IDLE. done stays high in IDLE.
//  - Timing: start accepted at the edge ending cycle t. Pattern k is on pi during cycle t+1+k.
//    Its response is sampled at the edge ending cycle t+1+k+DUT_LAT.
//    done first reads 1 in cycle t+1+2^N_IN+DUT_LAT.
//  - Sample tagging: a DUT_LAT-deep valid shift register carries the pattern index alongside the data.
//    Only tagged cycles update the metrics.
//  - Per valid sample: d = po_apx ^ po_exact; e = |po_apx - po_exact| (N_OUT+1-bit subtract, then abs).
//    If d != 0: mism_cnt+1; ham_sum += popcount(d); abs_sum += e; max_err = max(max_err, e).
//    first_fail captured only when fail_vld is 0; fail_vld then set.
//  - Metric widths are sized for the worst case, so no overflow or saturation logic is required.
//  - pi holds 2^N_IN-1 through DRAIN, DONE and IDLE until the next accepted start.
//  - start while busy: ignored (no restart, no metric clear).
//  - abort in SWEEP/DRAIN: go to IDLE next edge, busy=0, done stays 0, valid pipeline flushed.
//    Partial metrics hold until the next accepted start. abort in IDLE/DONE: no effect.
//  - Reset mid-sweep: immediate clear per reset rule; no completion reported.
// TESTING
//  1 N_IN=7,N_OUT=4,LAT=0, apx=exact=pi[6:4]+pi[3:1] -> after 128 patterns done=1;
//    mism_cnt=0, ham_sum=0, max_err=0, fail_vld=0.
//  2 Same exact; apx = exact with bit0 forced 0 -> mism_cnt=64, ham_sum=64, abs_sum=64,
//    max_err=1, first_fail=7'd2.
//  3 Test 2 with DUT_LAT=2 using registered copies -> identical metrics; start at cycle t gives done in cycle t+131.
//  4 abort in cycle t+50 -> busy=0 next cycle, done=0. Then start -> metrics cleared, full sweep matches test 2.
//  5 start pulses at t+10 and t+60 during SWEEP -> ignored; done at t+129; metrics as test 2.
//  6 rst_n low mid-sweep (pi=40) -> all outputs 0 immediately (async). After release, IDLE until start.

Source files
------------

// File: rtl/partition_sweep_checker.sv
// Exhaustive-sweep checker: drives every input pattern onto an exact and an approximate
// partition copy and accumulates mismatch count, Hamming sum, absolute-error sum and max error.
module partition_sweep_checker #(
  parameter int unsigned N_IN    = 7,
  parameter int unsigned N_OUT   = 4,
  parameter int unsigned DUT_LAT = 0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              abort,
  output logic [N_IN-1:0]                   pi,
  input  logic [N_OUT-1:0]                  po_exact,
  input  logic [N_OUT-1:0]                  po_apx,
  output logic                              busy,
  output logic                              done,
  output logic [N_IN:0]                     mism_cnt,
  output logic [N_IN+$clog2(N_OUT+1)-1:0]   ham_sum,
  output logic [N_IN+N_OUT-1:0]             abs_sum,
  output logic [N_OUT-1:0]                  max_err,
  output logic [N_IN-1:0]                   first_fail,
  output logic                              fail_vld
);

  localparam int unsigned HW  = $clog2(N_OUT + 1);
  localparam int unsigned MW  = N_IN + 1;
  localparam int unsigned HSW = N_IN + HW;
  localparam int unsigned ASW = N_IN + N_OUT;

  localparam logic [N_IN-1:0] PI_LAST    = '1;
  localparam logic [3:0]      DRAIN_LAST = (DUT_LAT == 0) ? 4'd0 : 4'(DUT_LAT - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SWEEP = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [3:0]      drain_q, drain_d;
  logic            accept;
  logic            kill;
  logic            sample_vld;
  logic [N_IN-1:0] sample_idx;
  logic            update;

  logic [N_OUT:0]   diff;
  logic [N_OUT-1:0] err;
  logic [N_OUT-1:0] bits;
  logic [HW-1:0]    pop;

  assign accept = (state_q == ST_IDLE) && start && !abort;
  assign kill   = abort && ((state_q == ST_SWEEP) || (state_q == ST_DRAIN));
  assign busy   = (state_q == ST_SWEEP) || (state_q == ST_DRAIN);

  always_comb begin
    state_d = state_q;
    drain_d = 4'd0;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_SWEEP;
      end
      ST_SWEEP: begin
        if (kill) begin
          state_d = ST_IDLE;
        end else if (pi == PI_LAST) begin
          state_d = (DUT_LAT == 0) ? ST_DONE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (kill) begin
          state_d = ST_IDLE;
        end else if (drain_q == DRAIN_LAST) begin
          state_d = ST_DONE;
        end else begin
          drain_d = drain_q + 4'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      drain_q <= 4'd0;
      pi      <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      if (accept) begin
        pi   <= '0;
        done <= 1'b0;
      end else begin
        if ((state_q == ST_SWEEP) && !kill && (pi != PI_LAST)) pi <= pi + N_IN'(1);
        if (state_d == ST_DONE) done <= 1'b1;
      end
    end
  end

  // Tag each driven pattern so its response is consumed exactly DUT_LAT cycles later.
  if (DUT_LAT == 0) begin : g_comb
    assign sample_vld = (state_q == ST_SWEEP);
    assign sample_idx = pi;
  end else begin : g_pipe
    logic [DUT_LAT-1:0] vld_sr;
    logic [N_IN-1:0]    idx_sr [DUT_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_sr <= '0;
        for (int i = 0; i < DUT_LAT; i++) idx_sr[i] <= '0;
      end else if (kill) begin
        vld_sr <= '0;
      end else begin
        vld_sr[0] <= (state_q == ST_SWEEP);
        idx_sr[0] <= pi;
        for (int i = 1; i < DUT_LAT; i++) begin
          vld_sr[i] <= vld_sr[i-1];
          idx_sr[i] <= idx_sr[i-1];
        end
      end
    end

    assign sample_vld = vld_sr[DUT_LAT-1];
    assign sample_idx = idx_sr[DUT_LAT-1];
  end

  // An aborting edge discards the in-flight sample along with the rest of the pipeline.
  assign update = sample_vld && !kill;

  always_comb begin
    diff = {1'b0, po_apx} - {1'b0, po_exact};
    err  = diff[N_OUT] ? N_OUT'(-diff) : diff[N_OUT-1:0];
    bits = po_apx ^ po_exact;
    pop  = '0;
    for (int i = 0; i < N_OUT; i++) pop = pop + HW'(bits[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mism_cnt   <= '0;
      ham_sum    <= '0;
      abs_sum    <= '0;
      max_err    <= '0;
      first_fail <= '0;
      fail_vld   <= 1'b0;
    end else if (accept) begin
      mism_cnt   <= '0;
      ham_sum    <= '0;
      abs_sum    <= '0;
      max_err    <= '0;
      first_fail <= '0;
      fail_vld   <= 1'b0;
    end else if (update && (bits != '0)) begin
      mism_cnt <= mism_cnt + MW'(1);
      ham_sum  <= ham_sum + HSW'(pop);
      abs_sum  <= abs_sum + ASW'(err);
      if (err > max_err) max_err <= err;
      // Patterns arrive in ascending order, so the first capture is the lowest failure.
      if (!fail_vld) begin
        first_fail <= sample_idx;
        fail_vld   <= 1'b1;
      end
    end
  end

endmodule
